mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one Wishbone-style memory port between the core's instruction-fetch interface and its data interface.
- Used in builds where `ENABLE_SECOND_MEMORY` is not defined and the Controller exposes only the core_* bus.
- Sits between `ssrv_top` (imem_*/dmem_* request/response ports) and the core_* bus.
- Performs round-robin arbitration, byte-strobe generation, request capture and registered response return.

Parameters:
- ADDR_WIDTH, 32, byte address width of both requesters and the bus.
- DATA_WIDTH, 32, data word width; fixed at 32 (strobe logic assumes 4 lanes).
- DMEM_FIXED_PRIO, 0, 1 = dmem always wins ties; 0 = round-robin.
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- imem_req  in  1  fetch request (level)
- imem_addr  in  ADDR_WIDTH  fetch byte address
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  one-cycle fetch completion pulse
- imem_err  out  1  one-cycle fetch error pulse
- dmem_req  in  1  data request (level)
- dmem_cmd  in  1  1 = write, 0 = read
- dmem_width  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- dmem_addr  in  ADDR_WIDTH  data byte address
- dmem_wdata  in  32  write data, right-aligned (LSBs)
- dmem_rdata  out  32  raw bus word, valid with dmem_resp
- dmem_resp  out  1  one-cycle data completion pulse
- dmem_err  out  1  one-cycle data error pulse
- core_cyc  out  1  bus transaction active
- core_stb  out  1  bus strobe; always equal to core_cyc
- core_we  out  1  bus write enable
- core_wstrb  out  4  byte lane strobes
- core_addr  out  ADDR_WIDTH  bus byte address (passed through unmodified)
- core_data_out  out  32  bus write data
- core_data_in  in  32  bus read data
- core_ack  in  1  bus acknowledge

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; all outputs 0.
  - last_grant=DMEM, so imem wins the first tie.
  - Reset mid-transaction abandons the transaction; no resp is issued.
- State IDLE:
  - Samples imem_req/dmem_req.
  - Neither requesting: stay in IDLE.
  - Exactly one requesting: grant it.
  - Both requesting, DMEM_FIXED_PRIO=0: grant the requester that is not last_grant.
  - Both requesting, DMEM_FIXED_PRIO=1: grant dmem.
  - On grant: capture addr/cmd/width/wdata into registers, update last_grant, go to BUS.
- State BUS:
  - core_cyc=core_stb=1; core_addr/we/wstrb/data_out driven from captured registers, stable until ack.
  - Imem grant: we=0, wstrb=4'b0000, data_out=0.
  - Write strobes:
    - byte: wstrb = 4'b0001 << addr[1:0]; data_out = {4{wdata[7:0]}}.
    - half: wstrb = 4'b0011 << {addr[1],1'b0}; addr[0] ignored; data_out = {2{wdata[15:0]}}.
    - word: wstrb = 4'b1111; data_out = wdata.
  - Read strobes: wstrb follows the same mapping, we=0, data_out=0.
  - On core_ack=1: register core_data_in, drop cyc/stb next cycle, go to RESP.
- State RESP (1 cycle):
  - Granted requester's resp=1; its rdata = registered word (raw, not lane-shifted).
  - Then go to IDLE. New requests are ignored during RESP.
- Latency:
  - req seen in IDLE at cycle N → cyc=1 at N+1.
  - Ack at cycle A → resp at A+1.
  - Minimum round trip is 3 cycles.
- Requester rule:
  - Requester drops req by the cycle after resp.
  - A req still high in the IDLE cycle after RESP is a new transaction.
- Ack outside BUS is ignored.
- rdata holds its last value between resp pulses.
- The resp and err outputs of the non-granted requester stay 0.

Optional Feature:
- Macro ARB_BUS_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop cyc/stb, go to RESP with err=1 instead of resp=1, rdata=32'hDEADBEEF.
  - Ack in the same cycle as the timeout takes precedence; normal resp is issued.
- Not defined:
  - No counter; BUS waits indefinitely.
  - imem_err and dmem_err tied to 0.

Test Plan:
- imem_req=1, imem_addr=0x100, dmem idle; ack after 2 cycles with data_in=0x00000013 → core_addr=0x100, we=0, wstrb=0; imem_resp pulses once one cycle after ack; imem_rdata=0x00000013.
- dmem byte write, addr=0x203, wdata=0xAB → wstrb=4'b1000, core_data_out=0xABABABAB, we=1; dmem_resp 1 cycle after ack.
- dmem half write, addr=0x202, wdata=0x1234 → wstrb=4'b1100, data_out=0x12341234.
- imem and dmem held high continuously, instant ack, DMEM_FIXED_PRIO=0 → grants alternate I,D,I,D; each resp is a single pulse.
- Same stimulus with DMEM_FIXED_PRIO=1 → only dmem is granted while dmem_req=1.
- rst=1 during BUS (cyc=1), ack arrives the next cycle → cyc=0 after reset, no resp emitted, next tie grants imem.
- With ARB_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack → cyc drops after 8 BUS cycles, dmem_err=1 for 1 cycle, dmem_resp=0, dmem_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one Wishbone-style memory port between the core's
// instruction-fetch (imem_*) and data (dmem_*) interfaces. Arbitration is
// round-robin or dmem-priority. A granted request is captured into registers
// and driven onto the core_* bus until ack. The read word comes back one
// cycle later as a single resp pulse.
//
// Optional build macro: ARB_BUS_TIMEOUT_EN adds a bus watchdog. After
// TIMEOUT_CYCLES bus cycles without ack, the transaction ends with an err
// pulse and rdata = 32'hDEADBEEF.
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   imem_req/addr                fetch request (level) and byte address
//   imem_rdata/resp/err          fetch data, completion pulse, error pulse
//   dmem_req/cmd/width/addr/wdata data request; cmd 1 = write; width 00 b, 01 h, 1x w
//   dmem_rdata/resp/err          raw bus word, completion pulse, error pulse
//   core_cyc/stb/we/wstrb/addr/data_out  bus master outputs (all registered)
//   core_data_in, core_ack       bus read data and acknowledge
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DMEM_FIXED_PRIO = 0,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_req,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,
  output logic                  imem_err,
  input  logic                  dmem_req,
  input  logic                  dmem_cmd,
  input  logic [1:0]            dmem_width,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,
  output logic                  dmem_err,
  output logic                  core_cyc,
  output logic                  core_stb,
  output logic                  core_we,
  output logic [3:0]            core_wstrb,
  output logic [ADDR_WIDTH-1:0] core_addr,
  output logic [DATA_WIDTH-1:0] core_data_out,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_ack
);

  // Lane logic assumes exactly four byte lanes, and the watchdog needs a nonzero limit.
  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("mem_bus_arbiter: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_dmem_q, last_dmem_d;   // last grant went to dmem
  logic                  gnt_dmem_q, gnt_dmem_d;     // current grant is dmem
  logic                  pick_dmem;
  logic                  timeout_hit;
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_data;

  logic                  cyc_d, we_d;
  logic [3:0]            wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] dout_d, imem_rdata_d, dmem_rdata_d;
  logic                  imem_resp_d, dmem_resp_d, imem_err_d, dmem_err_d;

  // Byte-lane strobes and replicated write data for the data requester.
  always_comb begin
    lane_strb = 4'b1111;
    lane_data = dmem_wdata;
    case (dmem_width)
      2'b00: begin
        lane_strb = 4'b0001 << dmem_addr[1:0];
        lane_data = {4{dmem_wdata[7:0]}};
      end
      2'b01: begin
        lane_strb = 4'b0011 << {dmem_addr[1], 1'b0};
        lane_data = {2{dmem_wdata[15:0]}};
      end
      default: begin
        lane_strb = 4'b1111;
        lane_data = dmem_wdata;
      end
    endcase
  end

  // On a tie, dmem wins when fixed priority is set or when imem had the last grant.
  assign pick_dmem = dmem_req && (!imem_req || (DMEM_FIXED_PRIO != 0) || !last_dmem_q);

`ifdef ARB_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Cycles spent in BUS; zero on entry, counts up while waiting for ack.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_BUS) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Ack in the same cycle wins over the timeout.
  assign timeout_hit = !core_ack && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_dmem_d  = last_dmem_q;
    gnt_dmem_d   = gnt_dmem_q;
    cyc_d        = core_cyc;
    we_d         = core_we;
    wstrb_d      = core_wstrb;
    addr_d       = core_addr;
    dout_d       = core_data_out;
    imem_rdata_d = imem_rdata;
    dmem_rdata_d = dmem_rdata;
    imem_resp_d  = 1'b0;
    dmem_resp_d  = 1'b0;
    imem_err_d   = 1'b0;
    dmem_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (imem_req || dmem_req) begin
          state_d     = S_BUS;
          gnt_dmem_d  = pick_dmem;
          last_dmem_d = pick_dmem;
          cyc_d       = 1'b1;
          addr_d      = pick_dmem ? dmem_addr : imem_addr;
          we_d        = pick_dmem && dmem_cmd;
          wstrb_d     = pick_dmem ? lane_strb : 4'b0000;
          dout_d      = (pick_dmem && dmem_cmd) ? lane_data : '0;
        end
      end
      S_BUS: begin
        if (core_ack || timeout_hit) begin
          state_d = S_RESP;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          addr_d  = '0;
          dout_d  = '0;
          if (gnt_dmem_q) begin
            dmem_resp_d  = core_ack;
            dmem_err_d   = !core_ack;
            dmem_rdata_d = core_ack ? core_data_in : DATA_WIDTH'(32'hDEADBEEF);
          end else begin
            imem_resp_d  = core_ack;
            imem_err_d   = !core_ack;
            imem_rdata_d = core_ack ? core_data_in : DATA_WIDTH'(32'hDEADBEEF);
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_dmem_q   <= 1'b1;
      gnt_dmem_q    <= 1'b0;
      core_cyc      <= 1'b0;
      core_we       <= 1'b0;
      core_wstrb    <= 4'b0000;
      core_addr     <= '0;
      core_data_out <= '0;
      imem_rdata    <= '0;
      dmem_rdata    <= '0;
      imem_resp     <= 1'b0;
      dmem_resp     <= 1'b0;
      imem_err      <= 1'b0;
      dmem_err      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_dmem_q   <= last_dmem_d;
      gnt_dmem_q    <= gnt_dmem_d;
      core_cyc      <= cyc_d;
      core_we       <= we_d;
      core_wstrb    <= wstrb_d;
      core_addr     <= addr_d;
      core_data_out <= dout_d;
      imem_rdata    <= imem_rdata_d;
      dmem_rdata    <= dmem_rdata_d;
      imem_resp     <= imem_resp_d;
      dmem_resp     <= dmem_resp_d;
      imem_err      <= imem_err_d;
      dmem_err      <= dmem_err_d;
    end
  end

  assign core_stb = core_cyc;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_resp, imem_err;
  logic          dmem_req, dmem_cmd;
  logic [1:0]    dmem_width;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          dmem_resp, dmem_err;
  logic          core_cyc, core_stb, core_we, core_ack;
  logic [3:0]    core_wstrb;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_data_out, core_data_in;

  // Fixed-priority instance: shares requester inputs and acks instantly.
  logic [DW-1:0] fp_imem_rdata, fp_dmem_rdata, fp_dout;
  logic          fp_imem_resp, fp_imem_err, fp_dmem_resp, fp_dmem_err;
  logic          fp_cyc, fp_stb, fp_we;
  logic [3:0]    fp_wstrb;
  logic [AW-1:0] fp_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .dmem_err(dmem_err),
    .core_cyc(core_cyc), .core_stb(core_stb), .core_we(core_we),
    .core_wstrb(core_wstrb), .core_addr(core_addr), .core_data_out(core_data_out),
    .core_data_in(core_data_in), .core_ack(core_ack)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DMEM_FIXED_PRIO(1), .TIMEOUT_CYCLES(255)) dut_fp (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(fp_imem_rdata),
    .imem_resp(fp_imem_resp), .imem_err(fp_imem_err),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(fp_dmem_rdata),
    .dmem_resp(fp_dmem_resp), .dmem_err(fp_dmem_err),
    .core_cyc(fp_cyc), .core_stb(fp_stb), .core_we(fp_we),
    .core_wstrb(fp_wstrb), .core_addr(fp_addr), .core_data_out(fp_dout),
    .core_data_in(core_data_in), .core_ack(fp_cyc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected strobes: byte selects lane addr%4, halfword selects the aligned pair.
  function automatic logic [3:0] exp_strb(input logic is_d, input logic [1:0] w, input logic [AW-1:0] a);
    int unsigned lane;
    lane = int'(a % 32'd4);
    if (!is_d) return 4'h0;
    case (w)
      2'd0:    return 4'(1 << lane);
      2'd1:    return 4'(3 << ((lane / 2) * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_dout(input logic is_d, input logic we, input logic [1:0] w,
                                           input logic [31:0] wd);
    if (!is_d || !we) return 32'h0;
    case (w)
      2'd0:    return (wd % 32'd256) * 32'h01010101;
      2'd1:    return (wd % 32'd65536) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  typedef struct {
    logic        is_d;
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input int idx);
    imem_req = !v.is_d; dmem_req = v.is_d;
    imem_addr = v.addr; dmem_addr = v.addr;
    dmem_cmd = v.cmd; dmem_width = v.width; dmem_wdata = v.wdata;
    @(negedge clk);
    chk1($sformatf("v%0d_cyc", idx), core_cyc, 1'b1);
    chk1($sformatf("v%0d_stb", idx), core_stb, 1'b1);
    chk($sformatf("v%0d_addr", idx), core_addr, v.addr);
    chk1($sformatf("v%0d_we", idx), core_we, v.exp_we);
    chk($sformatf("v%0d_wstrb", idx), 32'(core_wstrb), 32'(v.exp_wstrb));
    chk($sformatf("v%0d_dout", idx), core_data_out, v.exp_dout);
    for (int k = 0; k < v.ack_dly; k++) begin
      @(negedge clk);
      chk1($sformatf("v%0d_hold_cyc", idx), core_cyc, 1'b1);
      chk($sformatf("v%0d_hold_addr", idx), core_addr, v.addr);
      chk1($sformatf("v%0d_early_resp", idx), imem_resp | dmem_resp, 1'b0);
    end
    core_ack = 1'b1; core_data_in = v.rdata;
    @(negedge clk);
    core_ack = 1'b0; core_data_in = 32'h0BAD0BAD;
    chk1($sformatf("v%0d_cyc_drop", idx), core_cyc, 1'b0);
    chk1($sformatf("v%0d_iresp", idx), imem_resp, !v.is_d);
    chk1($sformatf("v%0d_dresp", idx), dmem_resp, v.is_d);
    chk($sformatf("v%0d_rdata", idx), v.is_d ? dmem_rdata : imem_rdata, v.rdata);
    chk1($sformatf("v%0d_err", idx), imem_err | dmem_err, 1'b0);
    imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk1($sformatf("v%0d_pulse", idx), imem_resp | dmem_resp, 1'b0);
    chk($sformatf("v%0d_rdata_hold", idx), v.is_d ? dmem_rdata : imem_rdata, v.rdata);
  endtask

  // Random-phase model state.
  int          phase;       // 0 idle, 1 bus, 2 resp
  int          ack_wait;
  logic        m_gnt_d, m_last_d, pick;
  logic        cap_we;
  logic [3:0]  cap_strb;
  logic [31:0] cap_addr, cap_dout, exp_rdata;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   gq[$];
    logic prev_resp;
    int   fp_i_cnt, fp_d_cnt, cyc_cnt, guard;

    rst = 1'b1; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_cmd = 1'b0;
    dmem_width = 2'b00; dmem_addr = '0; dmem_wdata = '0; core_ack = 1'b0; core_data_in = '0;

    vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h100, 32'h0,        2, 32'h00000013, 1'b0, 4'b0000, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 2'b00, 32'h203, 32'hAB,       1, 32'h55AA55AA, 1'b1, 4'b1000, 32'hABABABAB};
    vecs[2] = '{1'b1, 1'b1, 2'b01, 32'h202, 32'h1234,     0, 32'h0,        1'b1, 4'b1100, 32'h12341234};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h300, 32'hFFFFFFFF, 3, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 2'b00, 32'h401, 32'h0,        0, 32'h01020304, 1'b0, 4'b0010, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 2'b01, 32'h201, 32'hBEEF5678, 1, 32'h11112222, 1'b1, 4'b0011, 32'h56785678};
    vecs[6] = '{1'b1, 1'b1, 2'b11, 32'h010, 32'h89ABCDEF, 0, 32'h0F0F0F0F, 1'b1, 4'b1111, 32'h89ABCDEF};

    repeat (2) @(negedge clk);
    chk1("rst_cyc", core_cyc, 1'b0);
    chk1("rst_stb", core_stb, 1'b0);
    chk("rst_bus", {27'(core_addr | core_data_out), core_we, core_wstrb}, 32'h0);
    chk("rst_rdata", imem_rdata | dmem_rdata, 32'h0);
    chk("rst_resp", {28'h0, imem_resp, imem_err, dmem_resp, dmem_err}, 32'h0);
    chk1("fp_rst_zero", |{fp_imem_rdata, fp_dmem_rdata, fp_dout, fp_imem_resp, fp_imem_err,
                          fp_dmem_resp, fp_dmem_err, fp_cyc, fp_stb, fp_we, fp_wstrb, fp_addr}, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Both requesters held high with instant ack: round-robin alternates,
    // fixed-priority instance serves only dmem.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h1000;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h2000;
    prev_resp = 1'b0; fp_i_cnt = 0; fp_d_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk1("alt_both_resp", imem_resp & dmem_resp, 1'b0);
      chk1("alt_single_pulse", prev_resp & (imem_resp | dmem_resp), 1'b0);
      if (imem_resp) gq.push_back(1'b0);
      if (dmem_resp) gq.push_back(1'b1);
      prev_resp = imem_resp | dmem_resp;
      if (fp_imem_resp) fp_i_cnt++;
      if (fp_dmem_resp) fp_d_cnt++;
      core_ack = core_cyc;
      core_data_in = 32'(c);
    end
    imem_req = 1'b0; dmem_req = 1'b0; core_ack = 1'b0;
    chk("alt_grants", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < gq.size()) chk1($sformatf("alt_order%0d", k), gq[k], 1'(k % 2));
    chk("fp_imem_grants", 32'(fp_i_cnt), 32'd0);
    chk("fp_dmem_grants", 32'(fp_d_cnt), 32'd4);
    repeat (2) @(negedge clk);

    // Reset while an imem transaction is on the bus: no resp, next tie goes to imem.
    imem_req = 1'b1; imem_addr = 32'h500;
    @(negedge clk);
    chk1("rstbus_cyc_before", core_cyc, 1'b1);
    rst = 1'b1; imem_req = 1'b0;
    @(negedge clk);
    chk1("rstbus_cyc_after", core_cyc, 1'b0);
    rst = 1'b0; core_ack = 1'b1; core_data_in = 32'h77;
    @(negedge clk);
    core_ack = 1'b0;
    chk1("rstbus_no_resp1", imem_resp | dmem_resp, 1'b0);
    chk1("rstbus_cyc_idle", core_cyc, 1'b0);
    @(negedge clk);
    chk1("rstbus_no_resp2", imem_resp | dmem_resp, 1'b0);
    imem_req = 1'b1; imem_addr = 32'h600;
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h700;
    @(negedge clk);
    chk("rstbus_tie_addr", core_addr, 32'h600);
    chk1("rstbus_tie_we", core_we, 1'b0);
    core_ack = 1'b1; core_data_in = 32'h600D;
    @(negedge clk);
    core_ack = 1'b0; imem_req = 1'b0; dmem_req = 1'b0;
    chk1("rstbus_tie_iresp", imem_resp, 1'b1);
    chk1("rstbus_tie_dresp", dmem_resp, 1'b0);
    repeat (2) @(negedge clk);

`ifdef ARB_BUS_TIMEOUT_EN
    // No ack: bus held for exactly 8 cycles, then an err pulse with the poison word.
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'b10; dmem_addr = 32'h800;
    cyc_cnt = 0; guard = 0;
    do begin
      @(negedge clk);
      if (core_cyc) cyc_cnt++;
      guard++;
    end while (core_cyc && guard < 20);
    dmem_req = 1'b0;
    chk("to_bus_cycles", 32'(cyc_cnt), 32'd8);
    chk1("to_dmem_err", dmem_err, 1'b1);
    chk1("to_dmem_resp", dmem_resp, 1'b0);
    chk1("to_imem_err", imem_err, 1'b0);
    chk("to_rdata", dmem_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk1("to_err_pulse", dmem_err, 1'b0);
    @(negedge clk);
`else
    cyc_cnt = 0; guard = 0;
    chk1("no_to_err", imem_err | dmem_err, 1'b0);
`endif

    // Randomized traffic against a transaction-level model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    phase = 0; m_last_d = 1'b1; m_gnt_d = 1'b0; ack_wait = 0;
    cap_addr = '0; cap_dout = '0; cap_we = 1'b0; cap_strb = '0; exp_rdata = '0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      chk1("rnd_cyc", core_cyc, phase == 1);
      chk1("rnd_stb", core_stb, phase == 1);
      if (phase == 1) begin
        chk("rnd_addr", core_addr, cap_addr);
        chk1("rnd_we", core_we, cap_we);
        chk("rnd_wstrb", 32'(core_wstrb), 32'(cap_strb));
        chk("rnd_dout", core_data_out, cap_dout);
      end
      chk1("rnd_iresp", imem_resp, phase == 2 && !m_gnt_d);
      chk1("rnd_dresp", dmem_resp, phase == 2 && m_gnt_d);
      chk1("rnd_err", imem_err | dmem_err, 1'b0);
      if (phase == 2) chk("rnd_rdata", m_gnt_d ? dmem_rdata : imem_rdata, exp_rdata);

      // Requesters: keep req and payload steady until served, then maybe reissue at once.
      if (phase == 2 && !m_gnt_d) begin
        imem_req = 1'($urandom_range(0, 1));
        imem_addr = $urandom;
      end else if (!imem_req && $urandom_range(0, 3) == 0) begin
        imem_req = 1'b1;
        imem_addr = $urandom;
      end
      if ((phase == 2 && m_gnt_d) || (!dmem_req && $urandom_range(0, 3) == 0)) begin
        dmem_req = (phase == 2 && m_gnt_d) ? 1'($urandom_range(0, 1)) : 1'b1;
        dmem_cmd = 1'($urandom_range(0, 1));
        dmem_width = 2'($urandom_range(0, 3));
        dmem_addr = $urandom;
        dmem_wdata = $urandom;
      end

      // Memory side: ack after a random wait; stray acks outside the bus phase.
      core_data_in = $urandom;
      core_ack = (phase != 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (phase == 1) begin
        if (ack_wait == 0) core_ack = 1'b1;
        else ack_wait--;
      end

      case (phase)
        0: if (imem_req || dmem_req) begin
          pick = dmem_req && (!imem_req || !m_last_d);
          m_gnt_d = pick; m_last_d = pick;
          cap_addr = pick ? dmem_addr : imem_addr;
          cap_we = pick && dmem_cmd;
          cap_strb = exp_strb(pick, dmem_width, dmem_addr);
          cap_dout = exp_dout(pick, dmem_cmd, dmem_width, dmem_wdata);
          ack_wait = $urandom_range(0, 3);
          phase = 1;
        end
        1: if (core_ack) begin
          exp_rdata = core_data_in;
          phase = 2;
        end
        default: phase = 0;
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
